// File: rtl/jtpang_bank_resp.sv
// Four-bank read responder: arbitrates ba_rd requests onto one single-port, variable-latency word memory.
// Define JTPANG_BANK_RR_EN for round-robin arbitration; otherwise fixed priority, bank 0 highest.
module jtpang_bank_resp #(
    parameter int AW    = 22,
    parameter int BURST = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ba0_addr,
    input  logic [AW-1:0] ba1_addr,
    input  logic [AW-1:0] ba2_addr,
    input  logic [AW-1:0] ba3_addr,
    input  logic [3:0]    ba_rd,
    output logic [3:0]    ba_ack,
    output logic [3:0]    ba_dst,
    output logic [3:0]    ba_dok,
    output logic [3:0]    ba_rdy,
    output logic [15:0]   data_read,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic          mem_valid,
    input  logic [15:0]   mem_din,
    output logic [1:0]    dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0] LAST_BEAT = 2'(BURST - 1);

    state_t        state_q;
    logic [1:0]    win_q;
    logic [1:0]    beat_q;
    logic [3:0]    ack_q, dst_q, dok_q, rdy_q;
    logic [15:0]   data_q;
    logic [AW-1:0] addr_q;
    logic          rd_q;

    logic [1:0]    win_d;
    logic [AW-1:0] win_addr_d;
    logic [3:0]    win_oh;
    logic          grant;

    assign grant  = (state_q == IDLE) && (|ba_rd);
    assign win_oh = 4'b0001 << win_q;

`ifdef JTPANG_BANK_RR_EN
    // ptr_q is the first bank examined on the next arbitration.
    logic [1:0] ptr_q;

    always_comb begin
        win_d = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (ba_rd[ptr_q + 2'(i)]) win_d = ptr_q + 2'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
        end else if (grant) begin
            ptr_q <= win_d + 2'd1;
        end
    end
`else
    always_comb begin
        win_d = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (ba_rd[i]) win_d = 2'(i);
        end
    end
`endif

    always_comb begin
        case (win_d)
            2'd0:    win_addr_d = ba0_addr;
            2'd1:    win_addr_d = ba1_addr;
            2'd2:    win_addr_d = ba2_addr;
            default: win_addr_d = ba3_addr;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= 2'd0;
            beat_q  <= 2'd0;
            ack_q   <= 4'd0;
            dst_q   <= 4'd0;
            dok_q   <= 4'd0;
            rdy_q   <= 4'd0;
            data_q  <= 16'd0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
        end else begin
            ack_q <= 4'd0;
            dst_q <= 4'd0;
            dok_q <= 4'd0;
            rdy_q <= 4'd0;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        win_q   <= win_d;
                        addr_q  <= win_addr_d;
                        beat_q  <= 2'd0;
                        ack_q   <= 4'b0001 << win_d;
                        rd_q    <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (mem_valid) begin
                        data_q  <= mem_din;
                        rd_q    <= 1'b0;
                        dok_q   <= win_oh;
                        dst_q   <= (beat_q == 2'd0)      ? win_oh : 4'd0;
                        rdy_q   <= (beat_q == LAST_BEAT) ? win_oh : 4'd0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    // The word is already on data_read; decide whether another beat follows.
                    if (beat_q != LAST_BEAT) begin
                        beat_q  <= beat_q + 2'd1;
                        addr_q  <= addr_q + AW'(1);
                        rd_q    <= 1'b1;
                        state_q <= REQ;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ba_ack      = ack_q;
    assign ba_dst      = dst_q;
    assign ba_dok      = dok_q;
    assign ba_rdy      = rdy_q;
    assign data_read   = data_q;
    assign mem_addr    = addr_q;
    assign mem_rd      = rd_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/jtpang_bank_resp.md
# jtpang_bank_resp

Responder end of the four-bank SDRAM read interface used by the game cores: accepts `ba_rd` requests and returns `ba_ack`, `ba_dst`, `ba_dok`, `ba_rdy` and `data_read` on the game side. Arbitrates the four banks onto a single-port, variable-latency word memory. It is used for simulation and for small targets that back the game with on-chip or external single-port memory in place of the full SDRAM controller.

## Interface
Parameters:
- `AW`, 22, address width of bank and memory addresses
- `BURST`, 2, 16-bit words returned per request, legal range 1..4

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `ba0_addr`..`ba3_addr`  in  AW each  word address of the request for each bank
- `ba_rd`  in  4  per-bank read request, bit n = bank n
- `ba_ack`  out  4  one-cycle pulse: request accepted
- `ba_dst`  out  4  one-cycle pulse alongside the first data word
- `ba_dok`  out  4  one-cycle pulse on every valid `data_read` word
- `ba_rdy`  out  4  one-cycle pulse alongside the last data word
- `data_read`  out  16  shared read data, valid only while some `ba_dok` bit is high
- `mem_addr`  out  AW  memory word address
- `mem_rd`  out  1  memory read request, level
- `mem_valid`  in  1  one-cycle pulse: `mem_din` holds the word for `mem_addr`
- `mem_din`  in  16  memory read data

## Operation
- Three states: IDLE, REQ, DATA. Reset enters IDLE.
- **IDLE:** if `ba_rd` is non-zero, select a winner `w`, latch `ba<w>_addr` into `mem_addr`, clear beat counter, pulse `ba_ack[w]`, go to REQ. Otherwise stay in IDLE.
- **REQ:**
  - Hold `mem_rd`=1 and `mem_addr` stable.
  - On `mem_valid`: capture `mem_din`, drop `mem_rd` the next cycle, go to DATA.
- **DATA:** lasts one cycle.
  - `data_read` = captured word; `ba_dok[w]`=1.
  - `ba_dst[w]`=1 if beat 0; `ba_rdy[w]`=1 if beat = BURST-1.
  - If not the last beat: increment beat, set `mem_addr`+1, return to REQ. Otherwise return to IDLE.
- Requester rules:
  - Holds `ba_rd` and `ba<n>_addr` until it sees `ba_ack`.
  - Drops `ba_rd` the cycle after `ba_ack`.
  - A `ba_rd` bit seen high in IDLE is always a new request.
- Only one access is in flight. Other banks' `ba_rd` wait, unacknowledged, until the next IDLE.
- `mem_valid` outside REQ is ignored.
- `mem_addr` increment wraps modulo 2^AW; e.g. all-ones + 1 = 0.
- At most one bit of each output vector is high in any cycle.
- `data_read` holds its last value outside DATA.

## Timing
- Reset values: `ba_ack`, `ba_dst`, `ba_dok`, `ba_rdy` = 0; `mem_rd` = 0; `mem_addr` = 0; `data_read` = 0; beat = 0; round-robin pointer = bank 0.
- Asserting `rst_n` low mid-burst aborts the access immediately: no further `ba_dok` or `ba_rdy`, `mem_rd` low asynchronously. A `mem_valid` arriving afterwards is ignored.
- All outputs are registered.
- `ba_rd` high at edge k in IDLE gives:
  - `ba_ack` and `mem_rd` high in cycle k+1;
  - `mem_valid` at edge j gives `ba_dok` in cycle j+1.
- With zero-wait memory (`mem_valid` in the first REQ cycle), a request takes 1 + 2·BURST cycles from `ba_ack` to the cycle after `ba_rdy`.
- One IDLE cycle always separates consecutive requests.

## Configuration
- **`JTPANG_BANK_RR_EN` defined:** round-robin arbitration. The search starts at the bank after the last winner; the pointer updates on every `ba_ack`.
- **Not defined:** fixed priority, bank 0 highest and bank 3 lowest. No pointer is implemented.

## Test plan
- **Single beat:** BURST=1, `ba_rd`=4'b0100, `ba2_addr`=22'h1234, memory returns 16'hBEEF two cycles after `mem_rd` -> `ba_ack`=4'b0100 once, `mem_addr`=22'h1234, one cycle with `ba_dst`=`ba_dok`=`ba_rdy`=4'b0100 and `data_read`=16'hBEEF.
- **Burst:** BURST=2, bank 1 at 22'h0010, memory words 16'h1111 and 16'h2222 -> `mem_addr` goes 22'h0010 then 22'h0011. Beat 0 gives `ba_dst`+`ba_dok` with 16'h1111; beat 1 gives `ba_dok`+`ba_rdy` with 16'h2222.
- **Contention:** `ba_rd`=4'b1111 held per protocol -> with `JTPANG_BANK_RR_EN`, ack order is 0,1,2,3. Without it, bank 0 wins first, and if bank 0 re-requests each time, banks 1–3 wait.
- **Wrap:** `ba0_addr`=22'h3FFFFF with BURST=2 -> second `mem_addr`=22'h000000.
- **Mid-burst reset:** `rst_n` pulsed low after the first `ba_dok` of a BURST=4 access -> all outputs 0, no `ba_rdy`. A later `mem_valid` is ignored. The next `ba_rd`=4'b0001 is served normally, bank 0 first.
- **Stray `mem_valid`:** `mem_valid` pulsed in IDLE -> no `ba_dok`, `data_read` unchanged.
